// File: rtl/neptuno_joy_scanner_pkg.sv
// Shared types and constants for the Neptuno joystick chain scanner.
// Scanner states and the bit layout of each decoded joystick word.
package neptuno_joy_scanner_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

   // Bit positions inside JOY1/JOY2 (active high after inversion).
   localparam int unsigned JOY_UP    = 0;
   localparam int unsigned JOY_DOWN  = 1;
   localparam int unsigned JOY_LEFT  = 2;
   localparam int unsigned JOY_RIGHT = 3;
   localparam int unsigned JOY_FIRE1 = 4;
   localparam int unsigned JOY_FIRE2 = 5;
   localparam int unsigned JOY_FIRE3 = 6;
   localparam int unsigned JOY_START = 7;

   localparam int unsigned BITCNT_W = 5;

endpackage

// File: rtl/joy_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
// The tick marks each half-period of the generated joystick shift clock.
module joy_tick_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   output logic tick
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div;

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         div <= '0;
      end else if (div == DIV_LAST) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   assign tick = (div == DIV_LAST);

endmodule

// File: rtl/neptuno_joy_scanner.sv
// Drives the 74HC165 joystick chain (load + shift clock) and deserialises
// JOY_DATA into two registered active-high joystick words with a frame strobe.
module neptuno_joy_scanner
   import neptuno_joy_scanner_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned NBITS   = 16
) (
   input  logic               CLOCK_50,
   input  logic               RESET_N,
   input  logic               ENABLE,
   input  logic               JOY_DATA,
   output logic               JOY_CLK,
   output logic               JOY_LOAD_N,
   output logic [NBITS/2-1:0] JOY1,
   output logic [NBITS/2-1:0] JOY2,
   output logic               FRAME_STB
);

   localparam int unsigned HALF = NBITS / 2;
   localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(NBITS - 1);

   logic tick;

   state_t              state,    state_nx;
   logic                load_n,   load_n_nx;
   logic                shift_clk, shift_clk_nx;
   logic                phase,    phase_nx;
   logic [BITCNT_W-1:0] bitcnt,   bitcnt_nx;
   logic [NBITS-1:0]    raw,      raw_nx;
   logic [HALF-1:0]     joy1,     joy1_nx;
   logic [HALF-1:0]     joy2,     joy2_nx;
   logic                stb,      stb_nx;

   joy_tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .CLOCK_50(CLOCK_50),
      .RESET_N (RESET_N),
      .tick    (tick)
   );

   always_ff @(posedge CLOCK_50) begin
      if (!RESET_N) begin
         state     <= ST_IDLE;
         load_n    <= 1'b1;
         shift_clk <= 1'b0;
         phase     <= 1'b0;
         bitcnt    <= '0;
         raw       <= '0;
         joy1      <= '0;
         joy2      <= '0;
         stb       <= 1'b0;
      end else begin
         state     <= state_nx;
         load_n    <= load_n_nx;
         shift_clk <= shift_clk_nx;
         phase     <= phase_nx;
         bitcnt    <= bitcnt_nx;
         raw       <= raw_nx;
         joy1      <= joy1_nx;
         joy2      <= joy2_nx;
         stb       <= stb_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      load_n_nx    = load_n;
      shift_clk_nx = shift_clk;
      phase_nx     = phase;
      bitcnt_nx    = bitcnt;
      raw_nx       = raw;
      joy1_nx      = joy1;
      joy2_nx      = joy2;
      stb_nx       = 1'b0;

      if (tick) begin
         unique case (state)
            ST_IDLE: begin
               if (ENABLE) begin
                  load_n_nx = 1'b0;
                  state_nx  = ST_LOAD;
               end else begin
                  load_n_nx    = 1'b1;
                  shift_clk_nx = 1'b0;
               end
            end

            ST_LOAD: begin
               load_n_nx = 1'b1;
               bitcnt_nx = '0;
               phase_nx  = 1'b0;
               state_nx  = ST_SHIFT;
            end

            ST_SHIFT: begin
               if (!phase) begin
                  // Sample before raising the clock so bit 0 is the value present right after load.
                  for (int unsigned i = 0; i < NBITS; i++) begin
                     if (bitcnt == BITCNT_W'(i)) begin
                        raw_nx[i] = JOY_DATA;
                     end
                  end
                  shift_clk_nx = 1'b1;
                  phase_nx     = 1'b1;
               end else begin
                  shift_clk_nx = 1'b0;
                  phase_nx     = 1'b0;
                  if (bitcnt == LAST_BIT) begin
                     joy1_nx  = ~raw[HALF-1:0];
                     joy2_nx  = ~raw[NBITS-1:HALF];
                     stb_nx   = 1'b1;
                     state_nx = ST_IDLE;
                  end else begin
                     bitcnt_nx = bitcnt + 1'b1;
                  end
               end
            end

            default: begin
               state_nx = ST_IDLE;
            end
         endcase
      end
   end

   assign JOY_CLK    = shift_clk;
   assign JOY_LOAD_N = load_n;
   assign JOY1       = joy1;
   assign JOY2       = joy2;
   assign FRAME_STB  = stb;

endmodule

// File: tb/tb_neptuno_joy_scanner.sv
// Bench for neptuno_joy_scanner: two-'165 chain model, vector table,
// multi-cycle corner sequences and randomized frames against a frame-level model.
module tb_neptuno_joy_scanner;

   localparam int CLK_DIV = 4;
   localparam int NBITS   = 16;
   localparam int PERIOD  = (2 + 2 * NBITS) * CLK_DIV;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b1;
   logic       joy_data;
   logic       joy_clk, load_n, stb;
   logic [7:0] joy1, joy2;

   always #5 clk = ~clk;

   neptuno_joy_scanner #(
      .CLK_DIV(CLK_DIV),
      .NBITS  (NBITS)
   ) dut (
      .CLOCK_50  (clk),
      .RESET_N   (rst_n),
      .ENABLE    (enable),
      .JOY_DATA  (joy_data),
      .JOY_CLK   (joy_clk),
      .JOY_LOAD_N(load_n),
      .JOY1      (joy1),
      .JOY2      (joy2),
      .FRAME_STB (stb)
   );

   // Two cascaded '165s: parallel load while LOAD_N low, shift toward the output on JOY_CLK rise.
   logic [15:0] pattern = 16'hFFFF;
   logic [15:0] chain   = 16'hFFFF;
   logic        chain_prev_clk = 1'b0;
   assign joy_data = chain[0];

   always @(posedge clk) begin
      #1;
      if (!load_n) chain = pattern;
      else if (joy_clk && !chain_prev_clk) chain = {1'b1, chain[15:1]};
      chain_prev_clk = joy_clk;
   end

   // Passive observer of chain-side timing.
   int   cyc = 0, last_fall = -1, prev_fall = -1, low_len = 0;
   int   rises = 0, rises_at_stb = 0, overlap = 0;
   int   stb_run = 0, max_stb_run = 0, stb_total = 0;
   logic mon_prev_load_n = 1'b1, mon_prev_clk = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (!load_n && mon_prev_load_n) begin
         prev_fall = last_fall;
         last_fall = cyc;
         rises     = 0;
      end
      if (load_n && !mon_prev_load_n) low_len = cyc - last_fall;
      if (joy_clk && !mon_prev_clk) rises++;
      if (joy_clk && !load_n) overlap++;
      if (stb) begin
         stb_run++;
         stb_total++;
         rises_at_stb = rises;
      end else begin
         stb_run = 0;
      end
      if (stb_run > max_stb_run) max_stb_run = stb_run;
      mon_prev_load_n = load_n;
      mon_prev_clk    = joy_clk;
   end

   int vectors = 0, miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_stb(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         step();
         if (stb) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_stb_seen"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_fall(input string name, input int limit);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         step();
         if (!load_n) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_load_fall_seen"}, 32'(ok), 32'd1);
   endtask

   // Frame-level reference: bit i of the frame is the i-th bit leaving the chain after load.
   function automatic logic [15:0] expected_words(input logic [15:0] chain_value);
      logic [15:0] serial;
      for (int i = 0; i < 16; i++) serial[i] = chain_value[i];
      return {~serial[15:8], ~serial[7:0]};
   endfunction

   typedef struct {
      logic [15:0] raw;
      logic [7:0]  exp1;
      logic [7:0]  exp2;
   } vec_t;

   vec_t tv[7];
   int   rel;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tv[0] = '{16'hA55A, 8'hA5, 8'h5A};
      tv[1] = '{16'hFFFF, 8'h00, 8'h00};
      tv[2] = '{16'hFFFE, 8'h01, 8'h00};
      tv[3] = '{16'h0000, 8'hFF, 8'hFF};
      tv[4] = '{16'h1234, 8'hCB, 8'hED};
      tv[5] = '{16'h00FF, 8'h00, 8'hFF};
      tv[6] = '{16'hFF00, 8'hFF, 8'h00};

      // Reset held three cycles with ENABLE high.
      rst_n   = 1'b0;
      enable  = 1'b1;
      pattern = tv[0].raw;
      repeat (3) step();
      check("rst_joy_clk", 32'(joy_clk), 32'd0);
      check("rst_load_n",  32'(load_n),  32'd1);
      check("rst_joy1",    32'(joy1),    32'd0);
      check("rst_joy2",    32'(joy2),    32'd0);
      check("rst_stb",     32'(stb),     32'd0);
      rst_n = 1'b1;
      rel   = cyc;
      wait_fall("first", 20);
      check("first_load_latency", 32'(last_fall - rel), 32'd4);
      for (int i = 0; i < 20 && !load_n; i++) step();
      check("load_low_len", 32'(low_len), 32'(CLK_DIV));

      // Vector table; each pattern is installed right after the preceding strobe.
      for (int i = 0; i < 7; i++) begin
         wait_stb("tv", 400);
         check("tv_joy1", 32'(joy1), 32'(tv[i].exp1));
         check("tv_joy2", 32'(joy2), 32'(tv[i].exp2));
         check("tv_rises", 32'(rises_at_stb), 32'(NBITS));
         if (i > 0) check("tv_period", 32'(last_fall - prev_fall), 32'(PERIOD));
         if (i < 6) pattern = tv[i + 1].raw;
         step();
         check("tv_stb_width", 32'(stb), 32'd0);
         repeat (60) step();
         check("tv_hold_joy1", 32'(joy1), 32'(tv[i].exp1));
         check("tv_hold_joy2", 32'(joy2), 32'(tv[i].exp2));
      end

      // ENABLE dropped with bitcnt at 5: frame completes, then the chain parks.
      wait_stb("park_pre", 400);
      pattern = 16'h3C96;
      wait_fall("park", 20);
      for (int i = 0; i < 200 && !(rises == 5 && !joy_clk); i++) step();
      check("park_at_bit5", 32'(rises), 32'd5);
      enable = 1'b0;
      wait_stb("park_done", 400);
      check("park_joy", {16'h0, joy2, joy1}, {16'h0, expected_words(16'h3C96)});
      check("park_rises", 32'(rises_at_stb), 32'(NBITS));
      begin
         int bad;
         int stbs;
         bad  = 0;
         stbs = stb_total;
         for (int i = 0; i < 200; i++) begin
            step();
            if (!load_n || joy_clk) bad++;
         end
         check("park_hold", 32'(bad), 32'd0);
         check("park_no_stb", 32'(stb_total - stbs), 32'd0);
      end
      begin
         int c;
         c      = cyc;
         enable = 1'b1;
         wait_fall("resume", 8);
         check("resume_latency_ok", 32'((last_fall - c >= 1) && (last_fall - c <= CLK_DIV)), 32'd1);
         check("resume_tick_align", 32'((last_fall - rel) % CLK_DIV), 32'd0);
      end

      // Reset pulse at bitcnt 9, phase 1 aborts the frame without a strobe.
      for (int i = 0; i < 200 && !(rises == 10 && joy_clk); i++) step();
      check("abort_at_bit9", 32'(rises), 32'd10);
      begin
         int stbs;
         stbs  = stb_total;
         rst_n = 1'b0;
         step();
         rst_n = 1'b1;
         rel   = cyc;
         check("abort_joy_clk", 32'(joy_clk), 32'd0);
         check("abort_load_n",  32'(load_n),  32'd1);
         check("abort_joys",    {16'h0, joy2, joy1}, 32'd0);
         wait_fall("abort_restart", 20);
         check("abort_restart_latency", 32'(last_fall - rel), 32'd4);
         check("abort_no_stb", 32'(stb_total - stbs), 32'd0);
         wait_stb("abort_frame", 400);
         check("abort_frame_joy", {16'h0, joy2, joy1}, {16'h0, expected_words(pattern)});
      end

      // Randomized patterns and ENABLE idle gaps.
      for (int n = 0; n < 20; n++) begin
         logic [15:0] p;
         p       = 16'($urandom);
         pattern = p;
         enable  = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 100)) step();
         enable = 1'b1;
         wait_stb("rnd", 400);
         check("rnd_joy", {16'h0, joy2, joy1}, {16'h0, expected_words(p)});
         check("rnd_rises", 32'(rises_at_stb), 32'(NBITS));
      end

      check("stb_max_width", 32'(max_stb_run), 32'd1);
      check("clk_during_load", 32'(overlap), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
